// File: rtl/rns_ohc_pkg.sv
// Shared constants and helpers for the RNS one-hot-code datapath.
// Imported by the OHC adders, the OHC-to-binary converter and its encoder.
package rns_ohc_pkg;

  localparam int RNS_M0 = 7;
  localparam int RNS_M1 = 11;
  localparam int RNS_M2 = 13;

  localparam int OHC_M_MIN = 2;
  localparam int OHC_M_MAX = 64;

  // binary width needed to hold a residue 0..m-1
  function automatic int ohc_w(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ohc_encode.sv
// Combinational one-hot to binary encoder with invalid-code detection.
// Codes that are not exactly one-hot map to bin=0, err=1.
module ohc_encode
  import rns_ohc_pkg::*;
#(
  parameter int M = RNS_M1,
  localparam int W = ohc_w(M)
) (
  input  logic [M-1:0] ohc,
  output logic [W-1:0] bin,
  output logic         err
);

  logic [W-1:0] raw;
  logic         seen;
  logic         multi;

  // OR together the index of every set bit; exact for a true one-hot code
  always_comb begin
    raw = '0;
    for (int k = 0; k < M; k++) begin
      if (ohc[k]) raw = raw | W'(k);
    end
  end

  // popcount saturated at two: seen = one or more, multi = two or more
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < M; k++) begin
      multi = multi | (seen & ohc[k]);
      seen  = seen | ohc[k];
    end
  end

  assign err = !seen || multi;
  assign bin = err ? '0 : raw;

endmodule

// File: rtl/ohc_to_binary_pipe.sv
// Two-stage pipelined OHC to binary converter with valid/ready flow control
// and a saturating count of delivered words that carried an invalid code.
module ohc_to_binary_pipe
  import rns_ohc_pkg::*;
#(
  parameter int M = RNS_M1,
  parameter int CNT_W = 8,
  localparam int W = ohc_w(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_ohc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_bin,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         s1_valid;
  logic [M-1:0] s1_ohc;
  logic         s1_en;

  logic         s2_valid;
  logic [W-1:0] s2_bin;
  logic         s2_err;
  logic         s2_en;

  logic [W-1:0] enc_bin;
  logic         enc_err;
  logic         fire;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;

  assign out_valid = s2_valid;
  assign out_bin   = s2_bin;
  assign out_err   = s2_err;
  assign fire      = s2_valid && out_ready;

  ohc_encode #(
    .M(M)
  ) u_enc (
    .ohc(s1_ohc),
    .bin(enc_bin),
    .err(enc_err)
  );

  // stage 1: capture the raw code; data only moves with a valid word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ohc   <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_ohc <= in_ohc;
    end
  end

  // stage 2: capture the encoded result, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin <= enc_bin;
        s2_err <= enc_err;
      end
    end
  end

  // error counter: clear wins over a same-cycle increment, saturates at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (fire && s2_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ohc_to_binary_pipe.sv
// Directed bench for ohc_to_binary_pipe: scoreboard on the M=11 instance,
// plus a CNT_W=2 instance and M=7 / M=13 sweep instances.
module tb_ohc_to_binary_pipe;
  import rns_ohc_pkg::*;

  typedef struct packed {
    logic [3:0] bin;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_err, err_clr;
  logic [10:0] in_ohc;
  logic [3:0]  out_bin;
  logic [7:0]  err_cnt;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic        s_out_err, s_err_clr;
  logic [10:0] s_in_ohc;
  logic [3:0]  s_out_bin;
  logic [1:0]  s_err_cnt;

  logic        d7_in_valid, d7_in_ready, d7_out_valid, d7_out_ready;
  logic        d7_out_err, d7_err_clr;
  logic [6:0]  d7_in_ohc;
  logic [2:0]  d7_out_bin;
  logic [7:0]  d7_err_cnt;

  logic        d13_in_valid, d13_in_ready, d13_out_valid, d13_out_ready;
  logic        d13_out_err, d13_err_clr;
  logic [12:0] d13_in_ohc;
  logic [3:0]  d13_out_bin;
  logic [7:0]  d13_err_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ohc_to_binary_pipe #(.M(11), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ohc(in_ohc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  ohc_to_binary_pipe #(.M(11), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ohc(s_in_ohc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_bin(s_out_bin), .out_err(s_out_err),
    .err_clr(s_err_clr), .err_cnt(s_err_cnt)
  );

  ohc_to_binary_pipe #(.M(7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d7_in_valid), .in_ready(d7_in_ready), .in_ohc(d7_in_ohc),
    .out_valid(d7_out_valid), .out_ready(d7_out_ready),
    .out_bin(d7_out_bin), .out_err(d7_out_err),
    .err_clr(d7_err_clr), .err_cnt(d7_err_cnt)
  );

  ohc_to_binary_pipe #(.M(13)) dut13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d13_in_valid), .in_ready(d13_in_ready), .in_ohc(d13_in_ohc),
    .out_valid(d13_out_valid), .out_ready(d13_out_ready),
    .out_bin(d13_out_bin), .out_err(d13_out_err),
    .err_clr(d13_err_clr), .err_cnt(d13_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [10:0] ohc);
    exp_t e;
    e.bin = '0;
    e.err = ($countones(ohc) != 1);
    for (int k = 0; k < 11; k++) begin
      if (!e.err && ohc[k]) e.bin = 4'(k);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one word, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [10:0] ohc);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_ohc   = ohc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (ok) begin
      sb.push_back(model(ohc));
      tick();
    end else begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  // scoreboard: compare each completed output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_word", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("out_bin", 32'(out_bin), 32'(mon_e.bin));
        check("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_ohc = '0; out_ready = 1'b1; err_clr = 1'b0;
    s_in_valid = 1'b0; s_in_ohc = '0; s_out_ready = 1'b1; s_err_clr = 1'b0;
    d7_in_valid = 1'b0; d7_in_ohc = '0; d7_out_ready = 1'b1;
    d7_err_clr = 1'b0;
    d13_in_valid = 1'b0; d13_in_ohc = '0; d13_out_ready = 1'b1;
    d13_err_clr = 1'b0;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin", 32'(out_bin), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // streaming valid codes with no backpressure
    send(11'b00000000001);
    check("t1_in_ready0", 32'(in_ready), 32'd1);
    check("t1_lat_early", 32'(out_valid), 32'd0);
    send(11'b00000100000);
    check("t1_in_ready1", 32'(in_ready), 32'd1);
    check("t1_lat_valid", 32'(out_valid), 32'd1);
    check("t1_lat_bin", 32'(out_bin), 32'd0);
    send(11'b10000000000);
    check("t1_in_ready2", 32'(in_ready), 32'd1);
    drain();

    // invalid codes: zero bits and two bits
    check("t2_cnt0", 32'(err_cnt), 32'd0);
    send(11'b00000000000);
    send(11'b00000000011);
    tick();
    check("t2_cnt1", 32'(err_cnt), 32'd1);
    tick();
    check("t2_cnt2", 32'(err_cnt), 32'd2);
    drain();

    // backpressure: two words buffer, then in_ready drops and output holds
    out_ready = 1'b0;
    send(11'b00000000010);
    send(11'b00000000100);
    check("t3_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_ohc   = 11'b01000000000;
    repeat (4) begin
      tick();
      check("t3_hold_ready", 32'(in_ready), 32'd0);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_bin", 32'(out_bin), 32'd1);
    end
    out_ready = 1'b1;
    send(11'b01000000000);
    send(11'b00000000000);
    drain();
    check("t3_cnt", 32'(err_cnt), 32'd3);

    // saturation with a 2-bit counter, then clear against an errored transfer
    s_in_valid = 1'b1;
    s_in_ohc   = 11'b0;
    repeat (5) tick();
    s_in_valid = 1'b0;
    check("t4_cnt_max", 32'(s_err_cnt), 32'd3);
    repeat (2) tick();
    check("t4_cnt_sat", 32'(s_err_cnt), 32'd3);
    check("t4_in_ready", 32'(s_in_ready), 32'd1);
    s_in_valid = 1'b1;
    s_in_ohc   = 11'b00000000110;
    tick();
    s_in_valid = 1'b0;
    tick();
    check("t4_err_word", 32'({s_out_valid, s_out_err}), 32'd3);
    check("t4_err_bin", 32'(s_out_bin), 32'd0);
    s_err_clr = 1'b1;
    tick();
    s_err_clr = 1'b0;
    check("t4_clr_win", 32'(s_err_cnt), 32'd0);
    check("t4_drained", 32'(s_out_valid), 32'd0);

    // asynchronous reset with two words in flight
    send(11'b00000000000);
    send(11'b00000001000);
    check("t5_inflight", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_cnt", 32'(err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t5_ready", 32'(in_ready), 32'd1);
    tick();
    check("t5_empty", 32'(out_valid), 32'd0);
    send(11'b00100000000);
    check("t5_lat_early", 32'(out_valid), 32'd0);
    tick();
    check("t5_lat_valid", 32'(out_valid), 32'd1);
    check("t5_lat_bin", 32'(out_bin), 32'd8);
    drain();

    // sweep every one-hot code for M=7 and M=13
    for (int k = 0; k <= 13; k++) begin
      d7_in_valid  = (k < 7);
      d7_in_ohc    = 7'(1) << k;
      d13_in_valid = (k < 13);
      d13_in_ohc   = 13'(1) << k;
      tick();
      if (k >= 1 && k <= 7)
        check("m7_word", 32'({d7_out_err, d7_out_valid, d7_out_bin}),
              32'({1'b0, 1'b1, 3'(k - 1)}));
      if (k >= 1)
        check("m13_word", 32'({d13_out_err, d13_out_valid, d13_out_bin}),
              32'({1'b0, 1'b1, 4'(k - 1)}));
    end
    d7_in_valid  = 1'b0;
    d13_in_valid = 1'b0;
    tick();
    check("m7_cnt", 32'(d7_err_cnt), 32'd0);
    check("m13_cnt", 32'(d13_err_cnt), 32'd0);
    check("m7_ready", 32'(d7_in_ready), 32'd1);
    check("m13_ready", 32'(d13_in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
